serial_add_driver: RTL

Parallel-to-serial front end and serial-to-parallel back end for the team's bit-serial adder cell (one full adder plus a carry flop with synchronous active-high clear). The block accepts two WIDTH-bit operands on a valid/ready handshake and clears the serial adder. It then streams the operands LSB-first on `x`/`y`, collects the serial sum bits from `s`, and presents a WIDTH+1-bit parallel result with a one-cycle `done` pulse. It sits between a parallel datapath and the serial adder, with both blocks on the same `clk`.

---
 rtl/serial_add_driver_if.sv | 23 ++
 rtl/serial_add_driver.sv | 99 +++++++++
 2 files changed

// File: rtl/serial_add_driver_if.sv
// Parallel-side handshake bundle for serial_add_driver.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the 'sub' operand-mode bit.
interface serial_add_driver_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic [WIDTH:0]   sum;
  logic             done;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input ready, sum, done);
  modport slave  (input start, a, b, sub, output ready, sum, done);
`else
  modport master (output start, a, b, input ready, sum, done);
  modport slave  (input start, a, b, output ready, sum, done);
`endif
endinterface

// File: rtl/serial_add_driver.sv
// serial_add_driver: feeds two operands LSB-first into a bit-serial adder
// cell and reassembles the WIDTH+1-bit result.
// Optional feature macro: SERIAL_ADD_SUB_EN (subtract mode via bus.sub).
//
// state | meaning
// IDLE  | ready for operands
// CLR   | clearing the adder carry flop, x=y=0
// SHIFT | streaming a_sh[0]/b_sh[0], collecting s (WIDTH+1 cycles)
// DONE  | sum valid, one-cycle done pulse
module serial_add_driver #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_add_driver_if.slave   bus,
  output logic                 x,
  output logic                 y,
  output logic                 add_clr,
  input  logic                 s
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLR   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum_r;
  logic [WIDTH:0]   b_load;

  // Operand B as latched at accept; two's-complement negated in subtract mode.
  always_comb begin
    b_load = {1'b0, bus.b};
`ifdef SERIAL_ADD_SUB_EN
    if (bus.sub) begin
      b_load = ~{1'b0, bus.b} + 1'b1;
    end
`endif
  end

  // Sequencer, operand shifters, result collector and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      sum_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= {1'b0, bus.a};
            b_sh  <= b_load;
            cnt   <= '0;
            state <= CLR;
          end
        end
        CLR: begin
          state <= SHIFT;
        end
        SHIFT: begin
          a_sh <= {1'b0, a_sh[WIDTH:1]};
          b_sh <= {1'b0, b_sh[WIDTH:1]};
          res  <= {s, res[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            // Final s is the carry-out; res already holds bits 0..WIDTH-1.
            sum_r <= {s, res};
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // State decodes; reset forces the idle-side values in the same cycle.
  always_comb begin
    bus.ready = (state == IDLE) && !reset;
    bus.done  = (state == DONE) && !reset;
    bus.sum   = sum_r;
    x         = (state == SHIFT) && !reset && a_sh[0];
    y         = (state == SHIFT) && !reset && b_sh[0];
    add_clr   = reset || (state == CLR);
  end

endmodule
